mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the IF-stage fetch port and the M-stage data port.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_perf_ctr.sv | 25 ++
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// The state encoding matches the codes that the surrounding pipeline debug logic expects.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    // Wait-cycle performance counters (only present with MEM_ARB_PERF_EN)
    localparam int PERF_W   = 32;
    localparam int NUM_PERF = 2;   // index 0 = fetch port, 1 = data port

    // Bits needed to hold the starvation counter value 0..max
    function automatic int starve_width(input int max);
        int w;
        w = $clog2(max + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_perf_ctr.sv
// Free-running 32-bit (by default) event counter: counts cycles with en=1,
// wraps naturally, cleared by asynchronous reset.
module mem_port_arbiter_perf_ctr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    // Count enabled cycles; wraparound at 2^W is intended
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the IF fetch port and the
// M-stage data port. Data wins, except that a starvation counter forces a
// fetch grant after STARVE_MAX consecutive data grants with a fetch waiting.
// A fetch redirect (i_kill) lets the in-flight read finish but hides its result.
// Optional build macro: MEM_ARB_PERF_EN adds per-port stall-cycle counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    // fetch port
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    input  logic            i_kill,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ready,
    output logic            i_stall,
    // data port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ready,
    output logic            d_stall,
    // memory side
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_ack
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]     perf_i_wait,
    output logic [31:0]     perf_d_wait
`endif
);

    localparam int SW = starve_width(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_t      state_reg, state_next;
    logic [SW-1:0]   starve_cnt_reg, starve_cnt_next;
    logic            kill_pend_reg, kill_pend_next;
    logic            m_req_reg, m_req_next;
    logic            m_we_reg, m_we_next;
    logic [AW-1:0]   m_addr_reg, m_addr_next;
    logic [DW-1:0]   m_wdata_reg, m_wdata_next;
    logic [DW/8-1:0] m_wstrb_reg, m_wstrb_next;
    logic            grant_d, grant_i;

    // State and command registers; reset drops m_req immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ARB_IDLE;
            starve_cnt_reg <= '0;
            kill_pend_reg  <= 1'b0;
            m_req_reg      <= 1'b0;
            m_we_reg       <= 1'b0;
            m_addr_reg     <= '0;
            m_wdata_reg    <= '0;
            m_wstrb_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            kill_pend_reg  <= kill_pend_next;
            m_req_reg      <= m_req_next;
            m_we_reg       <= m_we_next;
            m_addr_reg     <= m_addr_next;
            m_wdata_reg    <= m_wdata_next;
            m_wstrb_reg    <= m_wstrb_next;
        end
    end

    // Arbitration, starvation bookkeeping and command capture
    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        kill_pend_next  = kill_pend_reg;
        m_req_next      = m_req_reg;
        m_we_next       = m_we_reg;
        m_addr_next     = m_addr_reg;
        m_wdata_next    = m_wdata_reg;
        m_wstrb_next    = m_wstrb_reg;
        grant_d         = 1'b0;
        grant_i         = 1'b0;

        case (state_reg)
            ARB_IDLE: begin
                if (d_req && (!i_req || (starve_cnt_reg < STARVE_LIM))) begin
                    grant_d = 1'b1;
                end else if (i_req && !i_kill && !kill_pend_reg) begin
                    grant_i = 1'b1;
                end

                if (grant_d) begin
                    state_next   = ARB_BUSY_D;
                    m_req_next   = 1'b1;
                    m_we_next    = d_we;
                    m_addr_next  = d_addr;
                    m_wdata_next = d_wdata;
                    // byte enables are meaningless for reads, so the memory sees none
                    m_wstrb_next = d_we ? d_wstrb : '0;
                    if (!i_req) begin
                        starve_cnt_next = '0;
                    end else if (starve_cnt_reg < STARVE_LIM) begin
                        starve_cnt_next = starve_cnt_reg + SW'(1);
                    end
                end else if (grant_i) begin
                    state_next      = ARB_BUSY_I;
                    m_req_next      = 1'b1;
                    m_we_next       = 1'b0;
                    m_addr_next     = i_addr;
                    m_wdata_next    = '0;
                    m_wstrb_next    = '0;
                    starve_cnt_next = '0;
                end else if (!i_req) begin
                    starve_cnt_next = '0;
                end
            end

            ARB_BUSY_I: begin
                if (m_ack) begin
                    state_next     = ARB_IDLE;
                    m_req_next     = 1'b0;
                    kill_pend_next = 1'b0;
                end else if (i_kill) begin
                    // the read cannot be withdrawn; remember to drop its data
                    kill_pend_next = 1'b1;
                end
            end

            ARB_BUSY_D: begin
                if (m_ack) begin
                    state_next = ARB_IDLE;
                    m_req_next = 1'b0;
                end
            end

            default: begin
                state_next = ARB_IDLE;
                m_req_next = 1'b0;
            end
        endcase
    end

    assign m_req   = m_req_reg;
    assign m_we    = m_we_reg;
    assign m_addr  = m_addr_reg;
    assign m_wdata = m_wdata_reg;
    assign m_wstrb = m_wstrb_reg;

    // Completion is combinational on the ack; a kill (pending or same-cycle) hides it
    assign i_ready = (state_reg == ARB_BUSY_I) && m_ack && !kill_pend_reg && !i_kill;
    assign d_ready = (state_reg == ARB_BUSY_D) && m_ack;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign i_stall = i_req && !i_ready;
    assign d_stall = d_req && !d_ready;

`ifdef MEM_ARB_PERF_EN
    logic [NUM_PERF-1:0] perf_en;
    logic [PERF_W-1:0]   perf_cnt [NUM_PERF];

    assign perf_en = {d_stall, i_stall};

    generate
        for (genvar gi = 0; gi < NUM_PERF; gi++) begin : g_perf
            mem_port_arbiter_perf_ctr #(
                .W(PERF_W)
            ) u_ctr (
                .clk   (clk),
                .rst   (rst),
                .en    (perf_en[gi]),
                .count (perf_cnt[gi])
            );
        end
    endgenerate

    assign perf_i_wait = perf_cnt[0];
    assign perf_d_wait = perf_cnt[1];
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus
// hand-written sequences for arbitration order, starvation, kill and reset.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req, i_kill, i_ready, i_stall;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ready, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_wait, perf_d_wait;
`endif

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
        .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ack(m_ack)
`ifdef MEM_ARB_PERF_EN
        , .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        logic [31:0] rdata;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
    } txn_t;

    txn_t vec [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for the command, check it, ack after 'waits' cycles, check completion.
    // Entered and left at posedge+1; on return the arbiter is in IDLE.
    task automatic do_txn(input string nm, input logic is_d, input logic exp_we,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_wstrb, input int waits, input logic [31:0] rdata);
        int n;
        n = 0;
        while (m_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_mreq"}, {31'd0, m_req}, 32'd1);
        if (m_req === 1'b1) begin
            chk({nm, "_maddr"}, m_addr, exp_addr);
            chk({nm, "_mwe"}, {31'd0, m_we}, {31'd0, exp_we});
            chk({nm, "_mwstrb"}, {28'd0, m_wstrb}, {28'd0, exp_wstrb});
            if (exp_we) chk({nm, "_mwdata"}, m_wdata, exp_wdata);
            for (int w = 0; w < waits; w++) begin
                #4;
                chk({nm, "_wait_rdy"}, {31'd0, is_d ? d_ready : i_ready}, 32'd0);
                step();
            end
            chk({nm, "_maddr_hold"}, m_addr, exp_addr);
            m_ack   = 1'b1;
            m_rdata = rdata;
            #4;
            chk({nm, "_rdy"}, {31'd0, is_d ? d_ready : i_ready}, 32'd1);
            chk({nm, "_other_rdy"}, {31'd0, is_d ? i_ready : d_ready}, 32'd0);
            chk({nm, "_rdata"}, is_d ? d_rdata : i_rdata, rdata);
            chk({nm, "_stall"}, {31'd0, is_d ? d_stall : i_stall}, 32'd0);
            step();
            m_ack = 1'b0;
            chk({nm, "_mreq_drop"}, {31'd0, m_req}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // is_d we addr wdata wstrb waits rdata exp_we exp_wstrb
        vec[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h0050_0093, 1'b0, 4'h0};
        vec[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 1'b0, 4'h0};
        vec[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1122_3344, 4'b0011, 2, 32'h0, 1'b1, 4'b0011};
        vec[3] = '{1'b1, 1'b1, 32'h0000_0044, 32'h5566_7788, 4'b0000, 3, 32'h0, 1'b1, 4'b0000};
        vec[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 3, 32'h1234_5678, 1'b0, 4'h0};
        vec[5] = '{1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4'b1100, 0, 32'h0, 1'b1, 4'b1100};

        rst = 1'b1;
        i_req = 0; i_addr = 0; i_kill = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        m_ack = 0; m_rdata = 0;
        #2;
        chk("rst_mreq", {31'd0, m_req}, 32'd0);
        chk("rst_mwe", {31'd0, m_we}, 32'd0);
        chk("rst_maddr", m_addr, 32'd0);
        chk("rst_mwstrb", {28'd0, m_wstrb}, 32'd0);
        chk("rst_iready", {31'd0, i_ready}, 32'd0);
        chk("rst_dready", {31'd0, d_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();

        // table-driven single transactions
        for (int k = 0; k < 6; k++) begin
            if (vec[k].is_d) begin
                d_we = vec[k].we; d_addr = vec[k].addr;
                d_wdata = vec[k].wdata; d_wstrb = vec[k].wstrb; d_req = 1'b1;
            end else begin
                i_addr = vec[k].addr; i_req = 1'b1;
            end
            do_txn($sformatf("vec%0d", k), vec[k].is_d, vec[k].exp_we, vec[k].addr,
                   vec[k].wdata, vec[k].exp_wstrb, vec[k].waits, vec[k].rdata);
            i_req = 1'b0;
            d_req = 1'b0;
            $display("vector %0d done addr=0x%08h", k, vec[k].addr);
        end

        // simultaneous requests: data first, fetch after d_ready
        i_addr = 32'h300; i_req = 1'b1;
        d_we = 1'b0; d_addr = 32'h2000; d_wstrb = 4'hF; d_req = 1'b1;
        do_txn("simul_d", 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 1, 32'hA5A5_0001);
        d_req = 1'b0;
        do_txn("simul_i", 1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 0, 32'hA5A5_0002);
        i_req = 1'b0;
        $display("simultaneous sequence done");

        // starvation: 4 data grants, 1 fetch grant, then the remaining data grants
        i_addr = 32'h500; i_req = 1'b1;
        d_we = 1'b1; d_wstrb = 4'hF; d_addr = 32'h1000; d_wdata = 32'd0; d_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                do_txn("starve_i", 1'b0, 1'b0, 32'h500, 32'h0, 4'h0, 0, 32'h0BAD_F00D);
                i_req = 1'b0;
            end
            d_addr  = 32'h1000 + 32'(4 * k);
            d_wdata = 32'(k);
            do_txn($sformatf("starve_d%0d", k), 1'b1, 1'b1, 32'h1000 + 32'(4 * k),
                   32'(k), 4'hF, k % 2, 32'h0);
        end
        d_req = 1'b0;
        $display("starvation sequence done");

        // kill during the 2nd BUSY_I cycle, ack after 2 waits
        i_addr = 32'h600; i_req = 1'b1;
        step();
        chk("kill_mreq", {31'd0, m_req}, 32'd1);
        chk("kill_maddr", m_addr, 32'h600);
        #4;
        chk("kill_stall_pre", {31'd0, i_stall}, 32'd1);
        step();
        i_kill = 1'b1; i_addr = 32'h700;
        #4;
        chk("kill_rdy_c2", {31'd0, i_ready}, 32'd0);
        step();
        i_kill = 1'b0; m_ack = 1'b1; m_rdata = 32'h0000_0BAD;
        #4;
        chk("kill_rdy_supp", {31'd0, i_ready}, 32'd0);
        chk("kill_maddr_one", m_addr, 32'h600);
        step();
        m_ack = 1'b0;
        chk("kill_idle", {31'd0, m_req}, 32'd0);
        do_txn("kill_next", 1'b0, 1'b0, 32'h700, 32'h0, 4'h0, 1, 32'h7777_0000);
        i_req = 1'b0;
        $display("kill sequence done");

        // kill in the ack cycle, then kill in IDLE blocking one grant
        i_addr = 32'h800; i_req = 1'b1;
        step();
        m_ack = 1'b1; m_rdata = 32'h8888_8888; i_kill = 1'b1;
        #4;
        chk("killack_rdy", {31'd0, i_ready}, 32'd0);
        step();
        m_ack = 1'b0; i_addr = 32'h804;
        step();
        chk("killidle_block", {31'd0, m_req}, 32'd0);
        i_kill = 1'b0;
        do_txn("killidle_next", 1'b0, 1'b0, 32'h804, 32'h0, 4'h0, 0, 32'h8040_0000);
        i_req = 1'b0;
        $display("kill-at-ack sequence done");

        // asynchronous reset in the middle of a store
        d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hFEED_0040; d_wstrb = 4'b0011; d_req = 1'b1;
        step();
        chk("arst_mreq", {31'd0, m_req}, 32'd1);
        chk("arst_mwe", {31'd0, m_we}, 32'd1);
        chk("arst_mwstrb", {28'd0, m_wstrb}, {28'd0, 4'b0011});
        m_ack = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_mreq_drop", {31'd0, m_req}, 32'd0);
        chk("arst_dready", {31'd0, d_ready}, 32'd0);
        chk("arst_iready", {31'd0, i_ready}, 32'd0);
        m_ack = 1'b0; d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("arst_idle", {31'd0, m_req}, 32'd0);
        i_addr = 32'h900; i_req = 1'b1;
        do_txn("arst_after", 1'b0, 1'b0, 32'h900, 32'h0, 4'h0, 2, 32'h0900_0900);
        i_req = 1'b0;
        $display("reset sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
